noc_flit_serializer: RTL and testbench

- Converts a parametrised NoC packet into a stream of FLIT_W-bit flits for narrow router links.
- Packet field layout is TYPE | SRC_X | SRC_Y | DST_X | DST_Y | PAYLOAD, packed MSB-first and generalised by COORD_W, TYPE_W and PAYLOAD_W.
- Sits between an endpoint network interface and the router local input port.
- Adds header-only ACK mode, illegal-type filtering, back-to-back packet acceptance and packet/drop counters.

---
 rtl/noc_flit_serializer_if.sv | 33 +++
 rtl/noc_flit_serializer.sv | 89 ++++++++
 tb/tb_noc_flit_serializer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/noc_flit_serializer_if.sv
// noc_flit_serializer_if: packet-in / flit-out handshake bundle for the NoC flit serializer.
//   master: endpoint side (drives packet fields and out_ready, observes flits)
//   slave : serializer side (accepts packets, drives the flit stream)
interface noc_flit_serializer_if #(
    parameter int TYPE_W    = 4,
    parameter int COORD_W   = 4,
    parameter int PAYLOAD_W = 44,
    parameter int FLIT_W    = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [TYPE_W-1:0]    in_type;
    logic [COORD_W-1:0]   in_src_x;
    logic [COORD_W-1:0]   in_src_y;
    logic [COORD_W-1:0]   in_dst_x;
    logic [COORD_W-1:0]   in_dst_y;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 out_valid;
    logic                 out_ready;
    logic [FLIT_W-1:0]    out_flit;
    logic                 out_head;
    logic                 out_tail;

    modport master (
        output in_valid, in_type, in_src_x, in_src_y, in_dst_x, in_dst_y, in_payload, out_ready,
        input  in_ready, out_valid, out_flit, out_head, out_tail
    );

    modport slave (
        input  in_valid, in_type, in_src_x, in_src_y, in_dst_x, in_dst_y, in_payload, out_ready,
        output in_ready, out_valid, out_flit, out_head, out_tail
    );
endinterface

// File: rtl/noc_flit_serializer.sv
// noc_flit_serializer: splits a TYPE|SRC_X|SRC_Y|DST_X|DST_Y|PAYLOAD packet into FLIT_W-bit flits.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : packet input handshake and flit output handshake
//   pkt_count         : packets fully sent (wraps)
//   drop_count        : packets dropped for illegal type (saturates)
module noc_flit_serializer #(
    parameter int TYPE_W    = 4,
    parameter int COORD_W   = 4,
    parameter int PAYLOAD_W = 44,
    parameter int FLIT_W    = 16,
    parameter bit SHORT_ACK = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    noc_flit_serializer_if.slave bus,
    output logic [CNT_W-1:0]    pkt_count,
    output logic [CNT_W-1:0]    drop_count
);
    localparam int PKT_W     = TYPE_W + 4 * COORD_W + PAYLOAD_W;
    localparam int HDR_W     = TYPE_W + 4 * COORD_W;
    localparam int NUM_FLITS = (PKT_W + FLIT_W - 1) / FLIT_W;
    localparam int HDR_FLITS = (HDR_W + FLIT_W - 1) / FLIT_W;
    localparam int PAD_W     = NUM_FLITS * FLIT_W;
    localparam int IDX_W     = NUM_FLITS > 1 ? $clog2(NUM_FLITS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [PAD_W-1:0]   vec_q, vec_d, pad, shifted;
    logic [IDX_W-1:0]   idx_q, idx_d, last_q, last_d;
    logic [CNT_W-1:0]   pkt_q, pkt_d, drop_q, drop_d;
    logic               hs, tail_hs, acc, legal, short_pkt;

    assign legal     = bus.in_type inside {TYPE_W'(1), TYPE_W'(2), TYPE_W'(4), TYPE_W'(8)};
    assign short_pkt = SHORT_ACK && bus.in_type == TYPE_W'(8);
    // Left-justify the packet so flit 0 always starts at the MSB; padding lands in the LSBs.
    assign pad       = PAD_W'({bus.in_type, bus.in_src_x, bus.in_src_y, bus.in_dst_x,
                               bus.in_dst_y, bus.in_payload}) << (PAD_W - PKT_W);
    assign shifted   = vec_q << (FLIT_W * int'(idx_q));

    assign bus.out_valid = state_q == SEND;
    assign bus.out_flit  = shifted[PAD_W-1 -: FLIT_W];
    assign bus.out_head  = bus.out_valid && idx_q == '0;
    assign bus.out_tail  = bus.out_valid && idx_q == last_q;
    assign hs            = bus.out_valid && bus.out_ready;
    assign tail_hs       = hs && bus.out_tail;
    // Accepting on the tail handshake lets the next packet follow without a bubble.
    assign bus.in_ready  = state_q == IDLE || tail_hs;
    assign acc           = bus.in_valid && bus.in_ready;
    assign pkt_count     = pkt_q;
    assign drop_count    = drop_q;

    always_comb begin
        state_d = tail_hs ? IDLE : state_q;
        idx_d   = hs ? idx_q + 1'b1 : idx_q;
        vec_d   = vec_q;
        last_d  = last_q;
        pkt_d   = tail_hs ? pkt_q + 1'b1 : pkt_q;
        drop_d  = drop_q;
        if (acc && legal) begin
            // Short ACKs carry only header bits; everything below the header is cleared.
            vec_d   = short_pkt ? pad & ~({PAD_W{1'b1}} >> HDR_W) : pad;
            idx_d   = '0;
            last_d  = short_pkt ? IDX_W'(HDR_FLITS - 1) : IDX_W'(NUM_FLITS - 1);
            state_d = SEND;
        end else if (acc) begin
            drop_d  = &drop_q ? drop_q : drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            pkt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            pkt_q   <= pkt_d;
            drop_q  <= drop_d;
        end
    end
endmodule

// File: tb/tb_noc_flit_serializer.sv
// tb_noc_flit_serializer: directed self-checking bench for noc_flit_serializer.
module tb_noc_flit_serializer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pkt_count, drop_count;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    noc_flit_serializer_if #(.TYPE_W(4), .COORD_W(4), .PAYLOAD_W(44), .FLIT_W(16)) bus ();

    noc_flit_serializer #(
        .TYPE_W(4), .COORD_W(4), .PAYLOAD_W(44), .FLIT_W(16), .SHORT_ACK(1'b1), .CNT_W(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_flit(input string tag, input logic [15:0] f, input logic h, input logic t);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_flit"}, 64'(bus.out_flit), 64'(f));
        check({tag, "_head"}, 64'(bus.out_head), 64'(h));
        check({tag, "_tail"}, 64'(bus.out_tail), 64'(t));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] t, input logic [3:0] sx, input logic [3:0] sy,
                         input logic [3:0] dx, input logic [3:0] dy, input logic [43:0] p);
        bus.in_valid   = 1'b1;
        bus.in_type    = t;
        bus.in_src_x   = sx;
        bus.in_src_y   = sy;
        bus.in_dst_x   = dx;
        bus.in_dst_y   = dy;
        bus.in_payload = p;
    endtask

    task automatic apply_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_type    = '0;
        bus.in_src_x   = '0;
        bus.in_src_y   = '0;
        bus.in_dst_x   = '0;
        bus.in_dst_y   = '0;
        bus.in_payload = '0;
        bus.out_ready  = 1'b1;
        #2;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_flit", 64'(bus.out_flit), 64'd0);
        check("rst_head", 64'(bus.out_head), 64'd0);
        check("rst_tail", 64'(bus.out_tail), 64'd0);
        check("rst_pkt", 64'(pkt_count), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        apply_reset();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // 1: basic four-flit packet
        drive(4'h2, 4'h1, 4'h2, 4'h3, 4'h4, 44'h123456789AB);
        check("t1_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        check_flit("t1_f0", 16'h2123, 1'b1, 1'b0);
        check("t1_busy", 64'(bus.in_ready), 64'd0);
        step();
        check_flit("t1_f1", 16'h4123, 1'b0, 1'b0);
        step();
        check_flit("t1_f2", 16'h4567, 1'b0, 1'b0);
        step();
        check_flit("t1_f3", 16'h89AB, 1'b0, 1'b1);
        step();
        check("t1_idle", 64'(bus.out_valid), 64'd0);
        check("t1_pkt", 64'(pkt_count), 64'd1);

        // 2: short ACK, header flits only with trailing bits cleared
        apply_reset();
        drive(4'h8, 4'h0, 4'h0, 4'h1, 4'h1, {44{1'b1}});
        step();
        bus.in_valid = 1'b0;
        check_flit("t2_f0", 16'h8001, 1'b1, 1'b0);
        step();
        check_flit("t2_f1", 16'h1000, 1'b0, 1'b1);
        step();
        check("t2_idle", 64'(bus.out_valid), 64'd0);
        check("t2_pkt", 64'(pkt_count), 64'd1);

        // 3: backpressure on flit 2
        apply_reset();
        drive(4'h2, 4'h1, 4'h2, 4'h3, 4'h4, 44'h123456789AB);
        step();
        bus.in_valid = 1'b0;
        check_flit("t3_f0", 16'h2123, 1'b1, 1'b0);
        step();
        check_flit("t3_f1", 16'h4123, 1'b0, 1'b0);
        step();
        bus.out_ready = 1'b0;
        check_flit("t3_f2", 16'h4567, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_flit("t3_hold", 16'h4567, 1'b0, 1'b0);
            check("t3_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        step();
        check_flit("t3_f3", 16'h89AB, 1'b0, 1'b1);
        step();
        check("t3_idle", 64'(bus.out_valid), 64'd0);
        check("t3_pkt", 64'(pkt_count), 64'd1);

        // 4: back-to-back packets, second accepted on the first tail edge
        apply_reset();
        drive(4'h2, 4'h1, 4'h2, 4'h3, 4'h4, 44'h123456789AB);
        step();
        drive(4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 44'hFEDCBA98765);
        check_flit("t4_a0", 16'h2123, 1'b1, 1'b0);
        check("t4_a0_rdy", 64'(bus.in_ready), 64'd0);
        step();
        check_flit("t4_a1", 16'h4123, 1'b0, 1'b0);
        step();
        check_flit("t4_a2", 16'h4567, 1'b0, 1'b0);
        step();
        check_flit("t4_a3", 16'h89AB, 1'b0, 1'b1);
        check("t4_a3_rdy", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        check_flit("t4_b0", 16'h4567, 1'b1, 1'b0);
        check("t4_pkt_mid", 64'(pkt_count), 64'd1);
        step();
        check_flit("t4_b1", 16'h8FED, 1'b0, 1'b0);
        step();
        check_flit("t4_b2", 16'hCBA9, 1'b0, 1'b0);
        step();
        check_flit("t4_b3", 16'h8765, 1'b0, 1'b1);
        step();
        check("t4_idle", 64'(bus.out_valid), 64'd0);
        check("t4_pkt", 64'(pkt_count), 64'd2);

        // 5: illegal type dropped, then a legal packet
        apply_reset();
        drive(4'h3, 4'h1, 4'h2, 4'h3, 4'h4, 44'h123456789AB);
        check("t5_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        check("t5_no_valid", 64'(bus.out_valid), 64'd0);
        check("t5_drop", 64'(drop_count), 64'd1);
        check("t5_pkt0", 64'(pkt_count), 64'd0);
        check("t5_ready", 64'(bus.in_ready), 64'd1);
        drive(4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 44'h123456789AB);
        step();
        bus.in_valid = 1'b0;
        check_flit("t5_f0", 16'h1123, 1'b1, 1'b0);
        step();
        check_flit("t5_f1", 16'h4123, 1'b0, 1'b0);
        step();
        check_flit("t5_f2", 16'h4567, 1'b0, 1'b0);
        step();
        check_flit("t5_f3", 16'h89AB, 1'b0, 1'b1);
        step();
        check("t5_pkt1", 64'(pkt_count), 64'd1);
        check("t5_drop1", 64'(drop_count), 64'd1);

        // 6: reset in the middle of a packet (counters are nonzero beforehand)
        drive(4'h2, 4'h1, 4'h2, 4'h3, 4'h4, 44'h123456789AB);
        step();
        bus.in_valid = 1'b0;
        step();
        check_flit("t6_f1", 16'h4123, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_valid_async", 64'(bus.out_valid), 64'd0);
        check("t6_flit_async", 64'(bus.out_flit), 64'd0);
        check("t6_tail_async", 64'(bus.out_tail), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("t6_in_ready", 64'(bus.in_ready), 64'd1);
        check("t6_pkt", 64'(pkt_count), 64'd0);
        check("t6_drop", 64'(drop_count), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("t6_no_flit", 64'(bus.out_valid), 64'd0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
